fb_scanout: RTL

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/fb_scanout.sv | 116 +++++++++++
 1 files changed

// File: rtl/fb_scanout.sv
// VGA scan-out engine: pixel-clock divider, h/v timing counters, 2x-upscaled
// framebuffer addressing and one-pixel-delayed colour/sync output registers.
module fb_scanout #(
    parameter int CLK_DIV         = 4,
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int DISP_ADDR_WIDTH = 17
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic                       fb_re,
    output logic [DISP_ADDR_WIDTH-1:0] fb_addr,
    input  logic [31:0]                fb_rdata,
    output logic [3:0]                 vga_r,
    output logic [3:0]                 vga_g,
    output logic [3:0]                 vga_b,
    output logic                       vga_hs,
    output logic                       vga_vs,
    output logic                       frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int AW    = DISP_ADDR_WIDTH;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [AW-1:0] ROW_W    = AW'(H_ACTIVE / 2);

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;

    logic          w_tick;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic          w_act;
    logic          w_act_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic          w_hs_low;
    logic          w_vs_low;
    logic          w_unused;

    assign w_unused = ^fb_rdata[31:12];

    always_comb begin
        w_tick   = (r_div == DIV_LAST);
        w_h_wrap = (r_h == H_LAST);
        w_v_wrap = (r_v == V_LAST);
        w_h_nxt  = r_h;
        w_v_nxt  = r_v;
        if (w_tick) begin
            w_h_nxt = w_h_wrap ? '0 : r_h + 1'b1;
            if (w_h_wrap) begin
                w_v_nxt = w_v_wrap ? '0 : r_v + 1'b1;
            end
        end
        w_act     = (r_h < H_ACT) && (r_v < V_ACT);
        w_act_nxt = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
        // Address is computed from the counters being entered so it is valid
        // for the whole pixel period, leaving CLK_DIV-1 clks for the read.
        w_addr_nxt = w_act_nxt ? (AW'(w_v_nxt >> 1) * ROW_W + AW'(w_h_nxt >> 1)) : '0;
        w_hs_low   = (r_h >= HS_FIRST) && (r_h <= HS_LAST);
        w_vs_low   = (r_v >= VS_FIRST) && (r_v <= VS_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div       <= '0;
            r_h         <= '0;
            r_v         <= '0;
            fb_re       <= 1'b0;
            fb_addr     <= '0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            r_div       <= w_tick ? '0 : r_div + 1'b1;
            r_h         <= w_h_nxt;
            r_v         <= w_v_nxt;
            fb_re       <= w_act_nxt;
            fb_addr     <= w_addr_nxt;
            frame_start <= w_tick && w_h_wrap && w_v_wrap;
            // Colour and sync describe the pixel period just ending.
            if (w_tick) begin
                vga_r  <= w_act ? fb_rdata[11:8] : '0;
                vga_g  <= w_act ? fb_rdata[7:4]  : '0;
                vga_b  <= w_act ? fb_rdata[3:0]  : '0;
                vga_hs <= ~w_hs_low;
                vga_vs <= ~w_vs_low;
            end
        end
    end

endmodule
